// File: rtl/sr_cond_pkg.sv
// sr_cond_pkg: debouncer state encoding and default timing constants.
package sr_cond_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;
  localparam int DEF_DEBOUNCE_CYCLES = 120000;
  localparam int DEF_CNT_WIDTH = 17;
endpackage

// File: rtl/sr_button_conditioner_if.sv
// sr_button_conditioner_if: raw button inputs and conditioned latch requests.
interface sr_button_conditioner_if;
  logic btn_set_raw;
  logic btn_reset_raw;
  logic set_pulse;
  logic reset_pulse;
  logic set_level;
  logic reset_level;
  logic conflict;
  modport master(output btn_set_raw, btn_reset_raw,
                 input set_pulse, reset_pulse, set_level, reset_level, conflict);
  modport slave(input btn_set_raw, btn_reset_raw,
                output set_pulse, reset_pulse, set_level, reset_level, conflict);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: 2-FF sync + counter debounce FSM; BTN_ACTIVE_LOW_EN inverts the raw input.
module debounce_channel
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse_req
);
  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s1_d, s2_q, s2_d, done;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
`ifdef BTN_ACTIVE_LOW_EN
  assign s1_d = ~raw;
`else
  assign s1_d = raw;
`endif
  assign s2_d = s1_q;
  assign done = cnt_q == TERM;
  assign level = state_q == IDLE_HIGH || state_q == WAIT_LOW;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pulse_req = 1'b0;
    case (state_q)
      IDLE_LOW: if (s2_q) begin
        state_d = WAIT_HIGH;
        cnt_d = CNT_WIDTH'(1);
      end
      WAIT_HIGH: if (!s2_q) begin
        state_d = IDLE_LOW;
        cnt_d = '0;
      end else if (done) begin
        state_d = IDLE_HIGH;
        cnt_d = '0;
        pulse_req = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      IDLE_HIGH: if (!s2_q) begin
        state_d = WAIT_LOW;
        cnt_d = CNT_WIDTH'(1);
      end
      WAIT_LOW: if (s2_q) begin
        state_d = IDLE_HIGH;
        cnt_d = '0;
      end else if (done) begin
        state_d = IDLE_LOW;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE_LOW;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
      state_q <= IDLE_LOW;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
endmodule

// File: rtl/sr_button_conditioner.sv
// sr_button_conditioner: debounced set/reset buttons with S=R=1 suppression (option BTN_ACTIVE_LOW_EN).
module sr_button_conditioner
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic clk,
  input logic rst,
  sr_button_conditioner_if.slave bus
);
  logic set_req, reset_req;
  logic set_pulse_q, set_pulse_d, reset_pulse_q, reset_pulse_d, conflict_q, conflict_d;
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_set (
    .clk(clk), .rst(rst), .raw(bus.btn_set_raw), .level(bus.set_level), .pulse_req(set_req)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_reset (
    .clk(clk), .rst(rst), .raw(bus.btn_reset_raw), .level(bus.reset_level), .pulse_req(reset_req)
  );
  // Requests are combinational so the registered pulse lands with the first level-high cycle.
  always_comb begin
    set_pulse_d = set_req & ~reset_req;
    reset_pulse_d = reset_req & ~set_req;
    conflict_d = set_req & reset_req;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      set_pulse_q <= 1'b0;
      reset_pulse_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      set_pulse_q <= set_pulse_d;
      reset_pulse_q <= reset_pulse_d;
      conflict_q <= conflict_d;
    end
  end
  assign bus.set_pulse = set_pulse_q;
  assign bus.reset_pulse = reset_pulse_q;
  assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_sr_button_conditioner.sv
// tb_sr_button_conditioner: directed + random stimulus against a run-length debounce model.
module tb_sr_button_conditioner;
  localparam int N = 4;
`ifdef BTN_ACTIVE_LOW_EN
  localparam logic ACT_LOW = 1'b1;
`else
  localparam logic ACT_LOW = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  sr_button_conditioner_if bus();
  sr_button_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // Model: s2 is the press value two non-reset edges old; a level flips after N
  // consecutive s2 samples disagreeing with it, and only rising flips request a pulse.
  logic [1:0] sq_s, sq_r;
  logic lv_s, lv_r, e_sp, e_rp, e_cf;
  int run_s, run_r;
  task automatic chan(input logic press, inout logic [1:0] sq, inout logic lv,
                      inout int run, output logic req);
    req = 1'b0;
    if (sq[1] != lv) begin
      run++;
      if (run == N) begin
        req = sq[1];
        lv = sq[1];
        run = 0;
      end
    end else run = 0;
    sq = {sq[0], press};
  endtask
  task automatic step(input logic rs, input logic ps, input logic pr);
    logic qs, qr;
    rst = rs;
    bus.btn_set_raw = ps ^ ACT_LOW;
    bus.btn_reset_raw = pr ^ ACT_LOW;
    @(posedge clk);
    if (rs) begin
      sq_s = '0; sq_r = '0; lv_s = 0; lv_r = 0; run_s = 0; run_r = 0;
      e_sp = 0; e_rp = 0; e_cf = 0;
    end else begin
      chan(ps, sq_s, lv_s, run_s, qs);
      chan(pr, sq_r, lv_r, run_r, qr);
      e_sp = qs & ~qr;
      e_rp = qr & ~qs;
      e_cf = qs & qr;
    end
    #1;
  endtask
  function automatic logic [4:0] obs();
    return {bus.set_level, bus.reset_level, bus.set_pulse, bus.reset_pulse, bus.conflict};
  endfunction
  function automatic logic [4:0] want();
    return {lv_s, lv_r, e_sp, e_rp, e_cf};
  endfunction
  task automatic test_reset();
    for (int i = 0; i < 12; i++) begin
      step(i < 2, 1'b1, 1'b1);
      tests++;
      if (obs() !== want() || (i < 2 && obs() !== 5'b0)) begin
        fails++;
        $display("FAIL reset cyc %0d: got %b want %b", i, obs(), want());
      end
    end
  endtask
  task automatic test_set_hold();
    int np = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step(1'b0, i >= 2, 1'b0);
      np += int'(bus.set_pulse);
      tests++;
      if (obs() !== want()) begin
        fails++;
        $display("FAIL set_hold cyc %0d: got %b want %b", i, obs(), want());
      end
    end
    tests++;
    if (np != 1) begin
      fails++;
      $display("FAIL set_hold pulse count: got %0d want 1", np);
    end
  endtask
  task automatic test_glitch();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, i < 10 ? ~i[0] : 1'b0);
      tests++;
      if (obs() !== want() || bus.reset_level !== 1'b0 || bus.reset_pulse !== 1'b0) begin
        fails++;
        $display("FAIL glitch cyc %0d: got %b want %b", i, obs(), want());
      end
    end
  endtask
  task automatic test_both();
    int nc = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, i >= 3, i >= 3);
      nc += int'(bus.conflict);
      tests++;
      if (obs() !== want() || (bus.set_pulse & bus.reset_pulse) !== 1'b0) begin
        fails++;
        $display("FAIL both cyc %0d: got %b want %b", i, obs(), want());
      end
    end
    tests++;
    if (nc != 1) begin
      fails++;
      $display("FAIL both conflict count: got %0d want 1", nc);
    end
  endtask
  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) begin
      step(i == 14, i < 10, i >= 10);
      tests++;
      if (obs() !== want() || (i == 14 && obs() !== 5'b0)) begin
        fails++;
        $display("FAIL reset_mid cyc %0d: got %b want %b", i, obs(), want());
      end
    end
  endtask
  task automatic test_random();
    logic ps = 1'b0, pr = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ps = ~ps;
      if ($urandom_range(7) == 0) pr = ~pr;
      step($urandom_range(299) == 0, ps, pr);
      tests++;
      if (obs() !== want() || (bus.set_pulse & bus.reset_pulse) !== 1'b0) begin
        fails++;
        $display("FAIL random cyc %0d: got %b want %b", i, obs(), want());
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.btn_set_raw = ACT_LOW;
    bus.btn_reset_raw = ACT_LOW;
    test_reset();
    test_set_hold();
    test_glitch();
    test_both();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
